mwadd_seq: RTL and testbench



---
 rtl/mwadd_seq_if.sv | 25 ++
 rtl/mwadd_seq.sv | 124 ++++++++++++
 tb/tb_mwadd_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mwadd_seq_if.sv
// Request/result bus of the multi-word addition sequencer.
// MWADD_SUB_EN adds the 'sub' request bit.
interface mwadd_seq_if #(
  parameter int WORDS = 4
);
  logic                  start;
  logic [32*WORDS-1:0]   op_a;
  logic [32*WORDS-1:0]   op_b;
  logic                  cin;
`ifdef MWADD_SUB_EN
  logic                  sub;
`endif
  logic                  busy;
  logic                  done;
  logic [32*WORDS-1:0]   sum;
  logic                  cout;

`ifdef MWADD_SUB_EN
  modport master (output start, op_a, op_b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, op_a, op_b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, op_a, op_b, cin, input busy, done, sum, cout);
  modport slave  (input start, op_a, op_b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/mwadd_seq.sv
// Feeds two WORDS x 32-bit operands through an external LCA_32, LSW first, chaining carries.
// Optional feature macro: MWADD_SUB_EN (A-B via inverted B and forced carry-in).
module mwadd_seq #(
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mwadd_seq_if.slave  bus,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_c0,
  input  logic [31:0] add_f,
  input  logic        add_c2
);

  localparam int WIDTH = 32 * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   sum_r;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic               cout_r;
  logic               busy_r;
  logic               done_r;
  logic               carry_init_s;
  logic               sub_r;

  // Subtraction starts the chain with carry 1 so that ~B + 1 forms -B.
`ifdef MWADD_SUB_EN
  assign carry_init_s = bus.sub ? 1'b1 : bus.cin;
`else
  assign carry_init_s = bus.cin;
  assign sub_r        = 1'b0;
`endif

  // Sequencer state, latched operands, word index, carry chain and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef MWADD_SUB_EN
      sub_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_r     <= bus.op_a;
            b_r     <= bus.op_b;
            idx_r   <= {IDX_W{1'b0}};
            carry_r <= carry_init_s;
            busy_r  <= 1'b1;
            state_r <= RUN;
`ifdef MWADD_SUB_EN
            sub_r   <= bus.sub;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          sum_r[32*idx_r +: 32] <= add_f;
          carry_r               <= add_c2;
          if (idx_r == LAST_IDX) begin
            cout_r  <= add_c2;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r + 1'b1;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Operand mux toward the adder; quiet (all zero) outside RUN.
  always_comb begin
    add_a  = 32'd0;
    add_b  = 32'd0;
    add_c0 = 1'b0;
    if (state_r == RUN) begin
      add_a  = a_r[32*idx_r +: 32];
      add_b  = sub_r ? ~b_r[32*idx_r +: 32] : b_r[32*idx_r +: 32];
      add_c0 = carry_r;
    end else begin
      add_a  = 32'd0;
      add_b  = 32'd0;
      add_c0 = 1'b0;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_mwadd_seq.sv
// Scoreboard bench for mwadd_seq with a behavioural LCA_32 stand-in and wide-arithmetic reference.
module tb_mwadd_seq;

  localparam int WORDS = 4;
  localparam int WIDTH = 32 * WORDS;

  logic        clk;
  logic        rst_n;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_c0;
  logic [31:0] add_f;
  logic        add_c2;

  mwadd_seq_if #(.WORDS(WORDS)) bus ();

  mwadd_seq #(.WORDS(WORDS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_c0 (add_c0),
    .add_f  (add_f),
    .add_c2 (add_c2)
  );

  // LCA_32 stand-in: a plain 32-bit add with carry.
  assign {add_c2, add_f} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_c0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bm;   // B as seen by the adder (inverted for subtraction)
    logic             c;
    int               se;   // edge at which start is sampled
  } op_t;

  op_t        sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [WIDTH-1:0] exp_sum = '0;
  logic             exp_cout = 1'b0;

  task automatic chk(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_wide();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WORDS; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Carry entering word w of the full-width sum a + bm + c.
  function automatic logic carry_into(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] bm,
                                      input logic c, input int w);
    logic [WIDTH:0] mask;
    logic [WIDTH:0] s;
    mask = ({{WIDTH{1'b0}}, 1'b1} << (32*w)) - 1'b1;
    s    = ({1'b0, a} & mask) + ({1'b0, bm} & mask) + {{WIDTH{1'b0}}, c};
    s    = s >> (32*w);
    return s[0];
  endfunction

  // Monitor: derives expected bus/adder activity from the head operation and checks results on done.
  always @(negedge clk) begin : mon
    logic             active;
    int               w;
    logic [31:0]      ea;
    logic [31:0]      eb;
    logic             ec;
    logic             edone;
    logic [WIDTH:0]   res;
    if (rst_n) begin
      active = (sb.size() > 0) && (cyc >= sb[0].se) && (cyc <= sb[0].se + WORDS);
      ea = 32'd0; eb = 32'd0; ec = 1'b0;
      if (active && (cyc < sb[0].se + WORDS)) begin
        w  = cyc - sb[0].se;
        ea = sb[0].a[32*w +: 32];
        eb = sb[0].bm[32*w +: 32];
        ec = carry_into(sb[0].a, sb[0].bm, sb[0].c, w);
      end
      edone = active && (cyc == sb[0].se + WORDS);
      chk("busy",   {{WIDTH{1'b0}}, bus.busy}, {{WIDTH{1'b0}}, active});
      chk("done",   {{WIDTH{1'b0}}, bus.done}, {{WIDTH{1'b0}}, edone});
      chk("add_a",  {{(WIDTH-31){1'b0}}, add_a}, {{(WIDTH-31){1'b0}}, ea});
      chk("add_b",  {{(WIDTH-31){1'b0}}, add_b}, {{(WIDTH-31){1'b0}}, eb});
      chk("add_c0", {{WIDTH{1'b0}}, add_c0}, {{WIDTH{1'b0}}, ec});
      if (!active) begin
        chk("hold", {bus.cout, bus.sum}, {exp_cout, exp_sum});
      end
      if (edone) begin
        res = {1'b0, sb[0].a} + {1'b0, sb[0].bm} + {{WIDTH{1'b0}}, sb[0].c};
        chk("result", {bus.cout, bus.sum}, res);
        exp_sum  = res[WIDTH-1:0];
        exp_cout = res[WIDTH];
        void'(sb.pop_front());
      end else if (sb.size() > 0 && cyc > sb[0].se + WORDS) begin
        n_cmp++;
        n_err++;
        $display("FAIL timeout @cyc %0d: got no done expected done at cyc %0d", cyc, sb[0].se + WORDS);
        void'(sb.pop_front());
      end
    end
  end

  task automatic scramble();
    bus.op_a = rnd_wide();
    bus.op_b = rnd_wide();
    bus.cin  = 1'($urandom);
`ifdef MWADD_SUB_EN
    bus.sub  = 1'($urandom);
`endif
  endtask

  // Starts one operation at a negedge, optionally pulses a spurious start at offset spur, waits for readiness.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input logic s, input int spur);
    op_t o;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
`ifdef MWADD_SUB_EN
    bus.sub   = s;
`endif
    o.a  = a;
    o.bm = s ? ~b : b;
    o.c  = s ? 1'b1 : c;
    o.se = cyc + 1;
    sb.push_back(o);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble();
    for (int j = 0; j < WORDS + 2; j++) begin
      @(negedge clk);
      if (j == spur) begin
        bus.start = 1'b1;
        scramble();
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  // Starts an operation then pulls reset two cycles in; the aborted result must never appear.
  task automatic abort_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_t o;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = 1'b0;
`ifdef MWADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    o.a = a; o.bm = b; o.c = 1'b0; o.se = cyc + 1;
    sb.push_back(o);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_sum  = '0;
    exp_cout = 1'b0;
    chk("rst_busy",  {{WIDTH{1'b0}}, bus.busy}, '0);
    chk("rst_done",  {{WIDTH{1'b0}}, bus.done}, '0);
    chk("rst_sum",   {bus.cout, bus.sum}, '0);
    chk("rst_adder", {{(WIDTH-64){1'b0}}, add_a, add_b, add_c0}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WORDS + 2) @(negedge clk);
  endtask

  logic [WIDTH-1:0] ones_w;
  logic [WIDTH-1:0] pa_w;
  logic [WIDTH-1:0] pb_w;
  logic [WIDTH-1:0] ra_w;

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
`ifdef MWADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_busy",  {{WIDTH{1'b0}}, bus.busy}, '0);
    chk("reset_done",  {{WIDTH{1'b0}}, bus.done}, '0);
    chk("reset_sum",   {bus.cout, bus.sum}, '0);
    chk("reset_adder", {{(WIDTH-64){1'b0}}, add_a, add_b, add_c0}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    ones_w = '1;
    for (int i = 0; i < WORDS; i++) begin
      pa_w[32*i +: 32] = 32'h0000ffff;
      pb_w[32*i +: 32] = 32'hffff0000;
    end
    issue('0, '0, 1'b0, 1'b0, -1);
    issue(ones_w, {{(WIDTH-1){1'b0}}, 1'b1}, 1'b0, 1'b0, -1);
    issue(pa_w, pb_w, 1'b1, 1'b0, -1);
    issue(rnd_wide(), rnd_wide(), 1'b1, 1'b0, 1);
    issue(rnd_wide(), rnd_wide(), 1'b0, 1'b0, WORDS);
    abort_op(ones_w, ones_w);
    issue(ones_w, ones_w, 1'b1, 1'b0, -1);

    for (int n = 0; n < 20; n++) begin
      ra_w = rnd_wide();
      if (n % 4 == 0) issue(ra_w, ~ra_w, 1'($urandom), 1'b0, -1);
      else            issue(ra_w, rnd_wide(), 1'($urandom), 1'b0, -1);
    end

`ifdef MWADD_SUB_EN
    issue({{(WIDTH-32){1'b0}}, 32'h00000900}, {{(WIDTH-32){1'b0}}, 32'h00000100}, 1'b0, 1'b1, -1);
    issue({{(WIDTH-32){1'b0}}, 32'h00000100}, {{(WIDTH-32){1'b0}}, 32'h00000900}, 1'b1, 1'b1, -1);
    for (int n = 0; n < 10; n++) begin
      issue(rnd_wide(), rnd_wide(), 1'($urandom), 1'($urandom), -1);
    end
`endif

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL pending: got %0d outstanding expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
